// File: rtl/stopwatch_tick_counter.sv
// Synchronizes the divided clock into a one-cycle tick and runs an MM:SS BCD
// stopwatch (00:00-59:59) under a start/stop/clear state machine.
module stopwatch_tick_counter #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       div_clock,
   input  logic       start_stop,
   input  logic       clear,
   output logic       tick,
   output logic       running,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       rollover
);

   localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES);

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] s;
   logic                   prev;
   logic                   armed;
   logic [2:0]             arm_cnt;

   // armed holds off edge detection until the sync chain and prev have
   // filled, so a div_clock already high at reset release is not a tick.
   always_ff @(posedge clock) begin
      if (reset) begin
         s       <= '0;
         prev    <= 1'b0;
         armed   <= 1'b0;
         arm_cnt <= 3'd0;
         tick    <= 1'b0;
      end else begin
         s    <= {s[SYNC_STAGES-2:0], div_clock};
         prev <= s[SYNC_STAGES-1];
         tick <= s[SYNC_STAGES-1] & ~prev & armed;
         if (!armed) begin
            if (arm_cnt == ARM_LAST) armed <= 1'b1;
            else                     arm_cnt <= arm_cnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= STOPPED;
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
         rollover <= 1'b0;
      end else begin
         rollover <= 1'b0;
         if (clear) begin
            state    <= STOPPED;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
         end else begin
            // Count on the current state, so a tick during a pause request
            // still counts and one during a resume request does not.
            if (state == RUNNING && tick) begin
               if (sec_ones != 4'd9) sec_ones <= sec_ones + 4'd1;
               else begin
                  sec_ones <= 4'd0;
                  if (sec_tens != 4'd5) sec_tens <= sec_tens + 4'd1;
                  else begin
                     sec_tens <= 4'd0;
                     if (min_ones != 4'd9) min_ones <= min_ones + 4'd1;
                     else begin
                        min_ones <= 4'd0;
                        if (min_tens != 4'd5) min_tens <= min_tens + 4'd1;
                        else begin
                           min_tens <= 4'd0;
                           rollover <= 1'b1;
                        end
                     end
                  end
               end
            end
            if (start_stop) state <= (state == RUNNING) ? PAUSED : RUNNING;
         end
      end
   end

   assign running = (state == RUNNING);

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// Directed scenarios plus randomized traffic against an elapsed-seconds model
// of the stopwatch, checked every cycle.
module tb_stopwatch_tick_counter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        div_clock = 1'b0;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;
   logic        tick, running, rollover;
   logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
   logic [15:0] digits;

   stopwatch_tick_counter #(.SYNC_STAGES(2)) dut (
      .clock(clock), .reset(reset), .div_clock(div_clock),
      .start_stop(start_stop), .clear(clear), .tick(tick),
      .running(running), .sec_ones(sec_ones), .sec_tens(sec_tens),
      .min_ones(min_ones), .min_tens(min_tens), .rollover(rollover)
   );

   assign digits = {min_tens, min_ones, sec_tens, sec_ones};

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: elapsed seconds, run flag, history of sampled div_clock
   int m_secs = 0;
   bit m_run = 0;
   bit m_tick = 0;
   bit m_roll = 0;
   int m_since_rst = 0;
   int m_ticks = 0;
   bit samp[$] = '{0, 0, 0};

   bit dc_free = 0;
   bit dc_rand = 0;
   int dc_half = 4;
   int dc_cnt = 0;
   int dut_ticks = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step(input bit ss, input bit clr, input bit rst);
      bit tick_old;
      logic [15:0] exp_d;
      start_stop = ss;
      clear = clr;
      reset = rst;
      if (dc_free) begin
         if (dc_cnt >= dc_half - 1) begin
            div_clock = ~div_clock;
            dc_cnt = 0;
            if (dc_rand) dc_half = $urandom_range(3, 7);
         end else dc_cnt++;
      end
      @(posedge clock);
      tick_old = m_tick;
      if (rst) begin
         m_secs = 0; m_run = 0; m_tick = 0; m_roll = 0; m_since_rst = 0;
         samp = '{0, 0, 0};
      end else begin
         m_roll = 0;
         if (clr) begin
            m_secs = 0; m_run = 0;
         end else begin
            if (m_run && tick_old) begin
               m_secs = (m_secs + 1) % 3600;
               m_roll = (m_secs == 0);
            end
            if (ss) m_run = !m_run;
         end
         samp.push_back(div_clock);
         if (samp.size() > 4) void'(samp.pop_front());
         // a rise seen two samples back, once three reset-free edges have passed
         m_tick = (m_since_rst >= 3) && samp[samp.size()-3] && !samp[samp.size()-4];
         if (m_since_rst < 3) m_since_rst++;
         if (m_tick) m_ticks++;
      end
      #1;
      exp_d[15:12] = 4'(m_secs / 600);
      exp_d[11:8]  = 4'((m_secs / 60) % 10);
      exp_d[7:4]   = 4'((m_secs % 60) / 10);
      exp_d[3:0]   = 4'(m_secs % 10);
      chk("tick", 16'(tick), 16'(m_tick));
      chk("running", 16'(running), 16'(m_run));
      chk("digits", digits, exp_d);
      chk("rollover", 16'(rollover), 16'(m_roll));
      if (tick === 1'b1) dut_ticks++;
   endtask

   initial begin
      int target;
      // 1: reset with div_clock high, then idle
      div_clock = 1'b1;
      repeat (3) step(0, 0, 1);
      chk("reset_digits", digits, 16'h0000);
      chk("reset_tick", 16'(tick), 16'h0000);
      repeat (10) step(0, 0, 0);
      chk("s1_no_tick", 16'(dut_ticks), 16'd0);
      chk("s1_running", 16'(running), 16'h0000);
      chk("s1_digits", digits, 16'h0000);

      // 2: start, then ten div_clock rises
      dc_free = 1; dc_cnt = 0;
      step(1, 0, 0);
      chk("s2_running", 16'(running), 16'h0001);
      dut_ticks = 0; m_ticks = 0;
      for (int i = 0; i < 200 && m_ticks < 10; i++) step(0, 0, 0);
      repeat (2) step(0, 0, 0);
      chk("s2_tick_count", 16'(dut_ticks), 16'd10);
      chk("s2_digits", digits, 16'h0010);

      // 3: run up to 59:58 and across the wrap
      for (int i = 0; i < 40000 && m_secs != 3598; i++) step(0, 0, 0);
      chk("s3_preload", digits, 16'h5958);
      for (int i = 0; i < 40 && m_secs != 3599; i++) step(0, 0, 0);
      chk("s3_5959", digits, 16'h5959);
      for (int i = 0; i < 40 && m_secs != 0; i++) step(0, 0, 0);
      chk("s3_wrap_digits", digits, 16'h0000);
      chk("s3_rollover", 16'(rollover), 16'h0001);
      step(0, 0, 0);
      chk("s3_rollover_low", 16'(rollover), 16'h0000);

      // 4: pause on the same cycle as a tick at 00:05
      for (int i = 0; i < 200 && !(m_secs == 5 && m_tick); i++) step(0, 0, 0);
      step(1, 0, 0);
      chk("s4_digits", digits, 16'h0006);
      chk("s4_running", 16'(running), 16'h0000);
      target = m_ticks + 5;
      for (int i = 0; i < 200 && m_ticks < target; i++) step(0, 0, 0);
      step(0, 0, 0);
      chk("s4_held", digits, 16'h0006);

      // 5: clear and start_stop together while paused
      step(1, 1, 0);
      chk("s5_digits", digits, 16'h0000);
      chk("s5_running", 16'(running), 16'h0000);

      // 6: reset during a tick at 12:34
      step(1, 0, 0);
      for (int i = 0; i < 8000 && !(m_secs == 754 && m_tick); i++) step(0, 0, 0);
      chk("s6_at_1234", digits, 16'h1234);
      step(0, 0, 1);
      chk("s6_digits", digits, 16'h0000);
      chk("s6_running", 16'(running), 16'h0000);
      chk("s6_tick", 16'(tick), 16'h0000);
      step(1, 0, 0);
      for (int i = 0; i < 200 && m_secs != 1; i++) step(0, 0, 0);
      step(0, 0, 0);
      chk("s6_restart", digits, 16'h0001);
      chk("s6_restart_running", 16'(running), 16'h0001);

      // randomized traffic with varying div_clock half-periods
      dc_rand = 1;
      for (int i = 0; i < 4000; i++)
         step($urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0,
              $urandom_range(0, 599) == 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_tick_counter.md
# stopwatch_tick_counter

Consumes the slow `div_clock` square wave from the ripple clock divider and turns it into a clean single-cycle `tick` in the system `clock` domain. It runs an MM:SS BCD stopwatch, 00:00 to 59:59, that advances on each tick. A start/stop/clear state machine controls the count. The BCD digits feed the seven-segment display driver directly downstream.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchronizer flops on `div_clock`. Legal range 2–4.

Ports:
- `clock`  in  1  system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `div_clock`  in  1  divided clock from the divider. Treated as an asynchronous data input; never used as a clock.
- `start_stop`  in  1  one-cycle pulse; toggles between run and pause.
- `clear`  in  1  one-cycle pulse; zeroes the count and stops.
- `tick`  out  1  one-cycle pulse per synchronized rising edge of `div_clock`.
- `running`  out  1  high while in the RUNNING state.
- `sec_ones`  out  4  BCD, 0–9.
- `sec_tens`  out  4  BCD, 0–5.
- `min_ones`  out  4  BCD, 0–9.
- `min_tens`  out  4  BCD, 0–5.
- `rollover`  out  1  one-cycle pulse when the count wraps from 59:59 to 00:00.

## Operation
Synchronizer and edge detect:
- `div_clock` passes through a `SYNC_STAGES` flop chain `s`, then one more flop `prev`.
- The next value of `tick` is `s[last] & ~prev & armed`. `tick` is registered.
- `armed` is cleared by reset. It sets after `SYNC_STAGES+1` cycles with reset low, counted by a small arm counter. This stops a `div_clock` that is already high at reset release from producing a false tick.

States (two-bit encoding is free):
- STOPPED: count is 00:00.
- RUNNING: the count advances.
- PAUSED: the count is held.

Transitions:
- `clear` in any state: go to STOPPED and zero all digits. `clear` has priority over `start_stop` and over a tick in the same cycle.
- STOPPED + `start_stop`: go to RUNNING.
- RUNNING + `start_stop`: go to PAUSED.
- PAUSED + `start_stop`: go to RUNNING.
- `start_stop` and `clear` both low: the state is held.

Counting:
- The count advances only when the current state is RUNNING and `tick`=1.
- A tick coincident with a RUNNING-to-PAUSED `start_stop` still advances the count.
- A tick coincident with a PAUSED-to-RUNNING `start_stop` does not advance the count.

Carry chain:
- `sec_ones` 9→0 carries into `sec_tens`.
- `sec_tens` 5→0 carries into `min_ones`.
- `min_ones` 9→0 carries into `min_tens`.
- `min_tens` 5→0 wraps the whole count to 00:00 and pulses `rollover`.
- Digits never hold non-BCD values or a tens digit above 5.

`running` is a decode of the state register.

## Timing
- Reset, checked at a `clock` edge: all outputs 0 and the state is STOPPED. The sync chain, `prev`, `armed` and the arm counter are all 0.
- Reset mid-count returns the block to this state at the next edge, regardless of the other inputs.
- Edge latency: `div_clock` first sampled high at edge k gives `tick`=1 in the cycle after edge k+`SYNC_STAGES`. That is `SYNC_STAGES+1` edges after the sampling edge, assuming `armed`=1.
- Digits update at the edge where `tick`=1 and the state is RUNNING, so they are visible one cycle after `tick`.
- `rollover` is high in that same cycle as the 00:00 digits and is low otherwise.
- `tick` asserts for exactly one cycle per `div_clock` rising edge. It asserts regardless of state, provided `armed`=1.
- `div_clock` must stay high and stay low for at least `SYNC_STAGES+1` `clock` cycles each. Faster input is out of spec.
- A `start_stop` or `clear` pulse takes effect at the next edge: `running` and the digits change one cycle after the pulse.

## Test plan
All scenarios use `SYNC_STAGES`=2 and `div_clock` toggling every 4 clocks (period 8).
1. Reset with `div_clock` held high, release reset, wait 10 cycles -> no `tick`. All digits 0, `running`=0.
2. After scenario 1, pulse `start_stop`, then run 10 `div_clock` rising edges -> `running`=1 one cycle after the pulse, exactly 10 single-cycle ticks, final digits 0,1,0,0 (`sec_ones`,`sec_tens`,`min_ones`,`min_tens`), i.e. 00:10. Each tick appears 3 edges after `div_clock` is first sampled high.
3. Preload 59:58 via 3598 ticks (or force), then give 2 more ticks -> digits 59:59, then 00:00 with `rollover`=1 for exactly one cycle alongside 00:00.
4. While RUNNING at 00:05, pulse `start_stop` in the same cycle as `tick`=1 -> count becomes 00:06. `running`=0 next cycle. 5 further ticks leave the count at 00:06.
5. In PAUSED at 00:06, assert `clear` and `start_stop` together -> STOPPED, digits 00:00, `running`=0.
6. While RUNNING at 12:34, assert `reset` for one cycle during a tick -> all outputs 0, no increment. A following `start_stop` restarts counting from 00:00.
